// File: rtl/axis_spi_pkg.sv
// rtl/axis_spi_pkg.sv - shared SPI/AXIS bridge constants and slave FSM state type
package axis_spi_pkg;

    // Defaults shared by the SPI master and slave at either chip edge
    localparam int SPI_DATA_WIDTH_DEF  = 8;
    localparam int SPI_SYNC_STAGES_DEF = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } spi_slave_state_e;

endpackage

// File: rtl/axis_if.sv
// rtl/axis_if.sv - AXI-Stream bundle with master/slave views
interface axis_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (output tdata, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/spi_if.sv
// rtl/spi_if.sv - four-wire SPI bundle with master/slave views
interface spi_if;
    logic clk;
    logic cs;
    logic mosi;
    logic miso;

    modport master (output clk, output cs, output mosi, input  miso);
    modport slave  (input  clk, input  cs, input  mosi, output miso);
endinterface

// File: rtl/axis_spi_sync.sv
// rtl/axis_spi_sync.sv - N-flop synchroniser with preset value and edge detect
module axis_spi_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic i_rst_val,
    input  logic i_pin,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    // Shift the pin through the chain; r_prev holds the previous synced value
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sync <= {STAGES{i_rst_val}};
            r_prev <= i_rst_val;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_pin};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_sync = r_sync[STAGES-1];
    assign o_rise = r_sync[STAGES-1] & ~r_prev;
    assign o_fall = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/axis_spi_slave.sv
// rtl/axis_spi_slave.sv - oversampled SPI target bridging MOSI/MISO onto AXI-Stream
module axis_spi_slave
    import axis_spi_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = SPI_SYNC_STAGES_DEF
) (
    input  logic   clk_i,
    input  logic   rst_i,
    input  logic   cpol_i,
    input  logic   cpha_i,
    spi_if.slave   s_spi,
    axis_if.slave  s_axis,
    axis_if.master m_axis,
    output logic   overrun_o,
    output logic   underrun_o
);

    localparam int                CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    logic w_sclk_sync, w_sclk_rise, w_sclk_fall;
    logic w_cs_sync,   w_cs_rise,   w_cs_fall;
    logic w_mosi_sync, w_mosi_rise, w_mosi_fall;
    logic w_unused;

    spi_slave_state_e r_state, w_next_state;

    logic [SYNC_STAGES:0]  r_settle;
    logic                  r_armed;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_rx_shift;
    logic [DATA_WIDTH-1:0] r_tx_shift;
    logic                  r_miso;
    logic [DATA_WIDTH-1:0] r_hold;
    logic                  r_hold_valid;
    logic                  r_flush_pend;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic                  r_tvalid;
    logic                  r_tlast;
    logic                  r_overrun;
    logic                  r_underrun;

    logic                  w_in_shift, w_lead, w_trail, w_sample, w_shift;
    logic                  w_start, w_end, w_word_done, w_load;
    logic [DATA_WIDTH-1:0] w_rx_word, w_tx_word;
    logic                  w_push, w_push_last, w_accept;
    logic [DATA_WIDTH-1:0] w_push_data;

    axis_spi_sync #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk_i(clk_i), .rst_i(rst_i), .i_rst_val(cpol_i), .i_pin(s_spi.clk),
        .o_sync(w_sclk_sync), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    axis_spi_sync #(.STAGES(SYNC_STAGES)) u_sync_cs (
        .clk_i(clk_i), .rst_i(rst_i), .i_rst_val(1'b1), .i_pin(s_spi.cs),
        .o_sync(w_cs_sync), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    axis_spi_sync #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk_i(clk_i), .rst_i(rst_i), .i_rst_val(1'b0), .i_pin(s_spi.mosi),
        .o_sync(w_mosi_sync), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    assign w_unused = &{1'b0, w_sclk_sync, w_mosi_rise, w_mosi_fall, s_axis.tlast};

    // The synchronisers are preset to CS high, so a CS already low at reset
    // release would look like a fall; only arm once CS is seen high after the
    // chains have flushed out their preset values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_settle <= '0;
            r_armed  <= 1'b0;
        end else begin
            r_settle <= {r_settle[SYNC_STAGES-1:0], 1'b1};
            if (r_settle[SYNC_STAGES] && w_cs_sync) begin
                r_armed <= 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next state: a frame spans synced CS fall to synced CS rise
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_cs_fall && r_armed) w_next_state = SHIFT;
            SHIFT:   if (w_cs_rise)            w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    assign w_in_shift  = (r_state == SHIFT);
    assign w_lead      = w_in_shift && (cpol_i ? w_sclk_fall : w_sclk_rise);
    assign w_trail     = w_in_shift && (cpol_i ? w_sclk_rise : w_sclk_fall);
    assign w_sample    = cpha_i ? w_trail : w_lead;
    assign w_shift     = cpha_i ? w_lead  : w_trail;
    assign w_start     = (r_state == IDLE) && w_cs_fall && r_armed;
    assign w_end       = w_in_shift && w_cs_rise;
    assign w_word_done = w_sample && (r_bit_cnt == LAST_BIT);
    assign w_rx_word   = {r_rx_shift[DATA_WIDTH-2:0], w_mosi_sync};

    // A word ending together with CS rise needs no further TX data
    assign w_load         = w_start || (w_word_done && !w_cs_rise);
    assign s_axis.tready  = w_load;
    assign w_tx_word      = s_axis.tvalid ? s_axis.tdata : '0;

    // RX deserialiser and per-word bit counter; partial words die with the frame
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
        end else if (w_start || w_end) begin
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
        end else if (w_sample) begin
            r_rx_shift <= w_rx_word;
            r_bit_cnt  <= w_word_done ? '0 : r_bit_cnt + 1'b1;
        end
    end

    // TX serialiser: in mode cpha=0 the first MSB must be on the wire before the
    // first leading edge, so it is driven straight from the CS-fall load; every
    // other bit, including later MSBs, is presented by a shift edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tx_shift <= '0;
            r_miso     <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= w_load && !s_axis.tvalid;
            if (w_end) begin
                r_tx_shift <= '0;
                r_miso     <= 1'b0;
            end else if (w_load) begin
                if (w_start && !cpha_i) begin
                    r_miso     <= w_tx_word[DATA_WIDTH-1];
                    r_tx_shift <= {w_tx_word[DATA_WIDTH-2:0], 1'b0};
                end else begin
                    r_tx_shift <= w_tx_word;
                end
            end else if (w_shift) begin
                r_miso     <= r_tx_shift[DATA_WIDTH-1];
                r_tx_shift <= {r_tx_shift[DATA_WIDTH-2:0], 1'b0};
            end
        end
    end

    // Decide which word, if any, goes to m_axis this cycle. When the final word
    // completes on the same cycle CS rises and an older word is held, the old
    // word goes now and the final one is flushed with tlast on the next cycle.
    always_comb begin
        w_push      = 1'b0;
        w_push_last = 1'b0;
        w_push_data = r_hold;
        if (r_flush_pend) begin
            w_push      = 1'b1;
            w_push_last = 1'b1;
        end else if (w_end) begin
            if (w_word_done && !r_hold_valid) begin
                w_push      = 1'b1;
                w_push_last = 1'b1;
                w_push_data = w_rx_word;
            end else if (r_hold_valid) begin
                w_push      = 1'b1;
                w_push_last = !w_word_done;
            end
        end else if (w_word_done && r_hold_valid) begin
            w_push = 1'b1;
        end
    end

    assign w_accept = !r_tvalid || m_axis.tready;

    // Hold register and m_axis output beat; a push onto a stalled beat is dropped
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_hold       <= '0;
            r_hold_valid <= 1'b0;
            r_flush_pend <= 1'b0;
            r_tdata      <= '0;
            r_tvalid     <= 1'b0;
            r_tlast      <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_tvalid && m_axis.tready) begin
                r_tvalid <= 1'b0;
            end
            if (w_push) begin
                if (w_accept) begin
                    r_tdata  <= w_push_data;
                    r_tlast  <= w_push_last;
                    r_tvalid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end
            if (r_flush_pend) begin
                r_flush_pend <= 1'b0;
                r_hold_valid <= 1'b0;
            end else if (w_end) begin
                r_hold_valid <= 1'b0;
                r_flush_pend <= w_word_done && r_hold_valid;
                if (w_word_done) begin
                    r_hold <= w_rx_word;
                end
            end else if (w_word_done) begin
                r_hold       <= w_rx_word;
                r_hold_valid <= 1'b1;
            end
        end
    end

    assign s_spi.miso    = r_miso;
    assign m_axis.tdata  = r_tdata;
    assign m_axis.tvalid = r_tvalid;
    assign m_axis.tlast  = r_tlast;
    assign overrun_o     = r_overrun;
    assign underrun_o    = r_underrun;

endmodule

// File: tb/tb_axis_spi_slave.sv
// tb/tb_axis_spi_slave.sv - randomized scoreboard bench for axis_spi_slave
module tb_axis_spi_slave;
    import axis_spi_pkg::*;

    localparam int DW   = 8;
    localparam int HALF = 8;

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cpol = 1'b0;
    logic cpha = 1'b0;
    logic ovr, unr;

    spi_if                      spi ();
    axis_if #(.DATA_WIDTH(DW))  txa ();
    axis_if #(.DATA_WIDTH(DW))  rxa ();

    axis_spi_slave #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .cpol_i     (cpol),
        .cpha_i     (cpha),
        .s_spi      (spi.slave),
        .s_axis     (txa.slave),
        .m_axis     (rxa.master),
        .overrun_o  (ovr),
        .underrun_o (unr)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int ovr_cnt = 0;
    int unr_win = 0;
    int tr_cnt  = 0;
    bit win     = 1'b0;
    bit tx_hs   = 1'b0;

    logic [DW-1:0] tx_q[$];
    beat_t         exp_q[$];
    beat_t         mon_b;
    logic [DW-1:0] m_mosi[4];
    logic [DW-1:0] m_tx[4];
    logic [DW-1:0] m_miso[4];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // TX word source: a handshake seen in the low phase retires the head word
    always @(negedge clk) tx_hs = txa.tvalid && txa.tready;

    always @(posedge clk) begin
        #1;
        if (tx_hs && tx_q.size() > 0) void'(tx_q.pop_front());
        tx_hs      = 1'b0;
        txa.tvalid = (tx_q.size() > 0);
        txa.tdata  = (tx_q.size() > 0) ? tx_q[0] : '0;
        txa.tlast  = 1'b0;
    end

    // Monitor: pulse counters and scoreboard pops on every m_axis handshake
    always @(negedge clk) begin
        if (!rst) begin
            if (ovr) ovr_cnt++;
            if (unr && win) unr_win++;
            if (txa.tready) tr_cnt++;
            if (rxa.tvalid && rxa.tready) begin
                if (exp_q.size() == 0) begin
                    check("beat_unexpected", {23'd0, rxa.tdata, rxa.tlast}, 32'hFFFF_FFFF);
                end else begin
                    mon_b = exp_q.pop_front();
                    check("beat_data", 32'(rxa.tdata), 32'(mon_b.d));
                    check("beat_last", 32'(rxa.tlast), 32'(mon_b.l));
                end
            end
        end
    end

    // SPI master model: nw words, the last one lb bits long; csl raises CS on
    // the final sample edge (cpha=1 only)
    task automatic spi_frame(input int nw, input int lb, input bit csl);
        int nb;
        bit fin;
        bit csl_done;
        csl_done = 1'b0;
        @(negedge clk);
        spi.cs = 1'b0;
        win    = 1'b1;
        repeat (HALF) @(negedge clk);
        for (int w = 0; w < nw; w++) begin
            nb = (w == nw - 1) ? lb : DW;
            m_miso[w] = '0;
            for (int b = 0; b < nb; b++) begin
                fin = (w == nw - 1) && (b == nb - 1);
                if (!cpha) begin
                    spi.mosi = m_mosi[w][DW-1-b];
                    repeat (HALF) @(negedge clk);
                    if (fin) win = 1'b0;
                    spi.clk = ~cpol;
                    m_miso[w][DW-1-b] = spi.miso;
                    repeat (HALF) @(negedge clk);
                    spi.clk = cpol;
                end else begin
                    spi.clk  = ~cpol;
                    spi.mosi = m_mosi[w][DW-1-b];
                    repeat (HALF) @(negedge clk);
                    if (fin) win = 1'b0;
                    spi.clk = cpol;
                    m_miso[w][DW-1-b] = spi.miso;
                    if (fin && csl) begin
                        spi.cs   = 1'b1;
                        csl_done = 1'b1;
                    end
                    repeat (HALF) @(negedge clk);
                end
            end
        end
        if (!csl_done) begin
            repeat (HALF) @(negedge clk);
            spi.cs = 1'b1;
        end
        win = 1'b0;
        repeat (2 * HALF) @(negedge clk);
    endtask

    // One frame with reference expectations: every complete MOSI word becomes a
    // beat, the last flagged; MISO carries the queued TX words or zeros; with
    // the sink stalled only the first beat survives and every later push overruns.
    task automatic run_frame(input bit p, input bit h, input int nw, input int lb,
                             input bit csl, input bit use_tx, input bit tlo);
        int    nfull;
        beat_t bt;
        @(negedge clk);
        cpol    = p;
        cpha    = h;
        spi.clk = p;
        repeat (10) @(negedge clk);
        nfull = (lb == DW) ? nw : nw - 1;
        if (use_tx) for (int i = 0; i < nw; i++) tx_q.push_back(m_tx[i]);
        repeat (2) @(negedge clk);
        if (tlo) begin
            if (nfull >= 1) begin
                bt.d = m_mosi[0];
                bt.l = (nfull == 1);
                exp_q.push_back(bt);
            end
        end else begin
            for (int i = 0; i < nfull; i++) begin
                bt.d = m_mosi[i];
                bt.l = (i == nfull - 1);
                exp_q.push_back(bt);
            end
        end
        ovr_cnt     = 0;
        unr_win     = 0;
        rxa.tready  = !tlo;
        spi_frame(nw, lb, csl);
        for (int w = 0; w < nfull; w++)
            check("miso_word", 32'(m_miso[w]), use_tx ? 32'(m_tx[w]) : 32'd0);
        repeat (10) @(negedge clk);
        rxa.tready = 1'b1;
        repeat (30) @(negedge clk);
        check("beats_left", exp_q.size(), 32'd0);
        check("overruns", ovr_cnt, (tlo && nfull > 1) ? 32'(nfull - 1) : 32'd0);
        if (use_tx || lb == DW)
            check("underruns", unr_win, use_tx ? 32'd0 : 32'(nfull));
        tx_q.delete();
        repeat (4) @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_miso"},   32'(spi.miso),   32'd0);
        check({tag, "_tvalid"}, 32'(rxa.tvalid), 32'd0);
        check({tag, "_tlast"},  32'(rxa.tlast),  32'd0);
        check({tag, "_tdata"},  32'(rxa.tdata),  32'd0);
        check({tag, "_tready"}, 32'(txa.tready), 32'd0);
        check({tag, "_ovr"},    32'(ovr),        32'd0);
        check({tag, "_unr"},    32'(unr),        32'd0);
        check({tag, "_fsm"},    32'(dut.r_state), 32'(IDLE));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0] mode;
        int         nw;
        bit         csl;

        spi.cs     = 1'b1;
        spi.clk    = 1'b0;
        spi.mosi   = 1'b0;
        rxa.tready = 1'b1;
        repeat (5) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // Mode 0, single word
        m_tx[0] = 8'h3C; m_mosi[0] = 8'hA5;
        run_frame(1'b0, 1'b0, 1, DW, 1'b0, 1'b1, 1'b0);

        // Mode 3, three words
        m_tx[0] = 8'h11; m_tx[1] = 8'h22; m_tx[2] = 8'h33;
        m_mosi[0] = 8'hDE; m_mosi[1] = 8'hAD; m_mosi[2] = 8'hBE;
        run_frame(1'b1, 1'b1, 3, DW, 1'b0, 1'b1, 1'b0);

        // Modes 1 and 2, asymmetric bit pattern
        m_tx[0] = 8'h81; m_mosi[0] = 8'h7E;
        run_frame(1'b0, 1'b1, 1, DW, 1'b0, 1'b1, 1'b0);
        run_frame(1'b1, 1'b0, 1, DW, 1'b0, 1'b1, 1'b0);

        // Underrun: nothing queued
        m_mosi[0] = 8'h5A; m_mosi[1] = 8'hC3;
        run_frame(1'b0, 1'b0, 2, DW, 1'b0, 1'b0, 1'b0);

        // Overrun: sink stalled over a three-word frame
        m_tx[0] = 8'h01; m_tx[1] = 8'h02; m_tx[2] = 8'h03;
        m_mosi[0] = 8'h9A; m_mosi[1] = 8'h4B; m_mosi[2] = 8'h6C;
        run_frame(1'b0, 1'b0, 3, DW, 1'b0, 1'b1, 1'b1);

        // CS rise on the final sample edge
        m_tx[0] = 8'hF0; m_tx[1] = 8'h0F;
        m_mosi[0] = 8'h37; m_mosi[1] = 8'hE1;
        run_frame(1'b0, 1'b1, 2, DW, 1'b1, 1'b1, 1'b0);

        // CS rise after 5 bits of word 2
        m_tx[0] = 8'hA0; m_tx[1] = 8'h0A;
        m_mosi[0] = 8'h96; m_mosi[1] = 8'hFF;
        run_frame(1'b0, 1'b0, 2, 5, 1'b0, 1'b1, 1'b0);

        // Reset mid-frame, then release with CS still low
        @(negedge clk);
        cpol = 1'b0; cpha = 1'b0; spi.clk = 1'b0;
        repeat (10) @(negedge clk);
        spi.cs = 1'b0;
        repeat (HALF) @(negedge clk);
        for (int b = 0; b < 3; b++) begin
            spi.mosi = b[0];
            repeat (HALF) @(negedge clk);
            spi.clk = 1'b1;
            repeat (HALF) @(negedge clk);
            spi.clk = 1'b0;
        end
        spi.clk = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_idle_outputs("midrst");
        spi.clk = 1'b0;
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        tr_cnt = 0;
        repeat (40) @(negedge clk);
        check("no_restart_tready", tr_cnt, 32'd0);
        check("no_restart_fsm", 32'(dut.r_state), 32'(IDLE));
        spi.cs = 1'b1;
        repeat (10) @(negedge clk);
        m_tx[0] = 8'hC5; m_mosi[0] = 8'h2D;
        run_frame(1'b0, 1'b0, 1, DW, 1'b0, 1'b1, 1'b0);

        // Randomized frames in random modes
        for (int k = 0; k < 8; k++) begin
            mode = 2'($urandom_range(0, 3));
            nw   = $urandom_range(1, 3);
            for (int i = 0; i < 4; i++) begin
                m_mosi[i] = DW'($urandom);
                m_tx[i]   = DW'($urandom);
            end
            csl = mode[0] && ($urandom_range(0, 1) == 1);
            run_frame(mode[1], mode[0], nw, DW, csl, 1'b1, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
